uart_hex_parser: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/ascii_hex_decode.sv | 28 ++
 rtl/uart_hex_parser.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART hex parser.
package uart_pkg;

  // Parser states: waiting for the high digit, waiting for the low digit, presenting a byte.
  typedef enum logic [1:0] {
    StWaitHi = 2'd0,
    StWaitLo = 2'd1,
    StOut    = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier: hex digit (with its value), separator, or neither.
module ascii_hex_decode
  import uart_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic       is_sep,
  output logic [3:0] nibble
);

  // Classify the character and compute its nibble value when it is a hex digit.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    is_sep = (ch == ASCII_SP) || (ch == ASCII_CR) || (ch == ASCII_LF);
    if (ch >= ASCII_0 && ch <= ASCII_0 + 8'd9) begin
      is_hex = 1'b1;
      nibble = 4'(ch - ASCII_0);
    end else if (ch >= ASCII_A_UC && ch <= ASCII_A_UC + 8'd5) begin
      is_hex = 1'b1;
      nibble = 4'(ch - ASCII_A_UC + 8'd10);
    end else if (ch >= ASCII_A_LC && ch <= ASCII_A_LC + 8'd5) begin
      is_hex = 1'b1;
      nibble = 4'(ch - ASCII_A_LC + 8'd10);
    end
  end

endmodule

// File: rtl/uart_hex_parser.sv
// Pairs ASCII hex digits (high nibble first) into bytes on a valid/ready stream.
// Optional inter-digit timeout enabled by defining HEX_PARSER_TIMEOUT_EN.
module uart_hex_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter int unsigned N_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       o_err,
  output logic       o_pending
);

  localparam int unsigned TimeoutCyc = CLK_FREQ / 1000 * TIMEOUT_MS;

  state_e     state_q, state_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic [7:0] m_tdata_q, m_tdata_d;
  logic       m_tvalid_q, m_tvalid_d;
  logic       err_q, err_d;

  logic       is_hex, is_sep;
  logic [3:0] nibble;
  logic       xfer;
  logic       timeout;

  // Character width is fixed at 8; the parameter exists only for interface compatibility.
  logic unused_n_bits;
  assign unused_n_bits = (N_BITS != 8);

  ascii_hex_decode u_decode (
    .ch     (s_tdata),
    .is_hex (is_hex),
    .is_sep (is_sep),
    .nibble (nibble)
  );

  assign s_tready  = (state_q != StOut);
  assign xfer      = s_tvalid && s_tready;
  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign o_err     = err_q;
  assign o_pending = (state_q == StWaitLo);

`ifdef HEX_PARSER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCyc + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside WAIT_LO, so it starts from zero on every entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StWaitLo) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StWaitLo) && (cnt_q == CntW'(TimeoutCyc - 1));

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCyc != 0);
  assign timeout = 1'b0;
`endif

  // Next-state and output-register logic for the digit-pairing FSM.
  always_comb begin
    state_d    = state_q;
    hi_nib_d   = hi_nib_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    err_d      = 1'b0;
    unique case (state_q)
      StWaitHi: begin
        if (xfer) begin
          if (is_hex) begin
            hi_nib_d = nibble;
            state_d  = StWaitLo;
          end else if (!is_sep) begin
            err_d = 1'b1;
          end
        end
      end
      StWaitLo: begin
        // A transfer beats a coincident timeout.
        if (xfer) begin
          if (is_hex) begin
            m_tdata_d  = {hi_nib_q, nibble};
            m_tvalid_d = 1'b1;
            state_d    = StOut;
          end else begin
            err_d    = 1'b1;
            hi_nib_d = 4'h0;
            state_d  = StWaitHi;
          end
        end else if (timeout) begin
          err_d    = 1'b1;
          hi_nib_d = 4'h0;
          state_d  = StWaitHi;
        end
      end
      StOut: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = StWaitHi;
        end
      end
      default: begin
        state_d = StWaitHi;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitHi;
      hi_nib_q   <= 4'h0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_nib_q   <= hi_nib_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      err_q      <= err_d;
    end
  end

endmodule
